// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants, fetch-state encoding and IF/ID record type
//               for the MIPS core front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: 32'h0, pc4: 32'h0, inst: NOP_INST, valid: 1'b0};

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_if.sv
// ============================================================================
// Module      : inst_fetch_if
// Description : Fetch-stage bundle: ROM address/data, decode control inputs
//               and the IF/ID register outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_fetch_if #(
  parameter int CNT_W = 16
);

  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic [31:0]      inst_addr;
  logic [31:0]      inst_in;
  logic [31:0]      ifid_pc;
  logic [31:0]      ifid_pc4;
  logic [31:0]      ifid_inst;
  logic             ifid_valid;
  logic [CNT_W-1:0] fetch_cnt;
  logic             halted;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, inst_in,
    output inst_addr, ifid_pc, ifid_pc4, ifid_inst, ifid_valid, fetch_cnt, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, inst_in,
    input  inst_addr, ifid_pc, ifid_pc4, ifid_inst, ifid_valid, fetch_cnt, halted
  );

endinterface

`default_nettype wire

// File: rtl/fetch_next_pc.sv
// ============================================================================
// Module      : fetch_next_pc
// Description : Combinational next-PC selection: redirect > stall > pc+4,
//               jump beating branch, with misaligned-target detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_next_pc
  import mips_pkg::*;
(
  input  wire logic [31:0] pc,
  input  wire logic        stall,
  input  wire logic        jump,
  input  wire logic [31:0] jump_target,
  input  wire logic        branch_taken,
  input  wire logic [31:0] branch_target,
  output logic      [31:0] next_pc,
  output logic             redirect,
  output logic             misaligned
);

  logic [31:0] w_target;

  always_comb begin
    w_target   = jump ? jump_target : branch_target;
    redirect   = jump | branch_taken;
    misaligned = redirect & ~is_word_aligned(w_target);
    next_pc    = pc + 32'(WORD_BYTES);
    // A bad target freezes pc; the caller turns it into a halt.
    if (redirect) begin
      next_pc = misaligned ? pc : w_target;
    end else if (stall) begin
      next_pc = pc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module      : inst_fetch
// Description : Instruction-fetch stage: PC, ROM addressing, IF/ID register,
//               saturating fetch counter and halt-on-misaligned-redirect FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  wire logic  clk,
  input  wire logic  rst,
  inst_fetch_if.master bus
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      w_pc_nxt;
  ifid_t            r_ifid;
  ifid_t            w_ifid_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_halted;
  logic             w_halted_nxt;

  logic [31:0]      w_next_pc;
  logic             w_redirect;
  logic             w_misaligned;

  fetch_next_pc u_next_pc (
    .pc            (r_pc),
    .stall         (bus.stall),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .next_pc       (w_next_pc),
    .redirect      (w_redirect),
    .misaligned    (w_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ifid_nxt   = r_ifid;
    w_cnt_nxt    = r_cnt;
    w_halted_nxt = r_halted;

    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end

      RUN: begin
        w_pc_nxt = w_next_pc;
        if (w_redirect) begin
          w_ifid_nxt = IFID_BUBBLE;
          if (w_misaligned) begin
            w_halted_nxt = 1'b1;
            w_state_nxt  = HALT;
          end
        end else if (!bus.stall) begin
          w_ifid_nxt = '{pc: r_pc, pc4: r_pc + 32'(WORD_BYTES), inst: bus.inst_in, valid: 1'b1};
          w_cnt_nxt  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + c_cnt_one;
        end
      end

      HALT: begin
        w_ifid_nxt   = IFID_BUBBLE;
        w_halted_nxt = 1'b1;
      end

      default: begin
        // Unreachable encoding: park safely in HALT.
        w_ifid_nxt   = IFID_BUBBLE;
        w_halted_nxt = 1'b1;
        w_state_nxt  = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_ifid   <= IFID_BUBBLE;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_ifid   <= w_ifid_nxt;
      r_cnt    <= w_cnt_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  assign bus.inst_addr  = r_pc;
  assign bus.ifid_pc    = r_ifid.pc;
  assign bus.ifid_pc4   = r_ifid.pc4;
  assign bus.ifid_inst  = r_ifid.inst;
  assign bus.ifid_valid = r_ifid.valid;
  assign bus.fetch_cnt  = r_cnt;
  assign bus.halted     = r_halted;

endmodule

`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage of the MIPS core. It owns the program counter and drives the instruction ROM address. It captures the ROM's combinational instruction word into the IF/ID pipeline register for the decode stage. It also accepts stall and redirect (branch/jump) requests from decode and halts on a misaligned redirect target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
CNT_W, 16, width of the fetched-instruction counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hazard stall from decode; hold PC and IF/ID
branch_taken  input  1  decode resolved a taken branch this cycle
branch_target  input  32  byte address of the branch target
jump  input  1  decode has a j instruction this cycle
jump_target  input  32  byte address of the jump target
inst_addr  output  32  byte address to the instruction ROM (= pc)
inst_in  input  32  instruction word from ROM, combinational on inst_addr
ifid_pc  output  32  address of the captured instruction
ifid_pc4  output  32  ifid_pc + 4
ifid_inst  output  32  captured instruction; 32'h0 (nop) when bubble
ifid_valid  output  1  IF/ID holds a real instruction
fetch_cnt  output  CNT_W  instructions captured since reset; saturating
halted  output  1  fetch has stopped after an address error

Behaviour:
- Reset (async, active-high): pc=RESET_PC, ifid_pc=0, ifid_pc4=0, ifid_inst=0, ifid_valid=0, fetch_cnt=0, halted=0, state=BOOT.
- inst_addr = pc, combinational. The ROM uses inst_addr[9:2] and is combinational, so inst_in is sampled in the same cycle it is addressed.
- Fetch latency: an instruction at pc appears on ifid_* one clock after pc is presented.
- FSM has three states: BOOT, RUN, HALT.
- BOOT: lasts exactly one cycle after reset deasserts. pc holds, IF/ID keeps its bubble, inputs are ignored. Next state is RUN.
- RUN priority is redirect > stall > sequential.
  - redirect = jump | branch_taken. If both are high, jump wins (target = jump_target).
  - Redirect with target[1:0]==2'b00: pc <= target. IF/ID <= bubble (valid=0, inst=0, pc/pc4=0). fetch_cnt unchanged. The redirect overrides stall.
  - Redirect with target[1:0]!=0: pc holds. IF/ID <= bubble. halted <= 1. Next state is HALT.
  - Stall with no redirect: pc and all ifid_* hold their values. fetch_cnt unchanged.
  - Sequential: pc <= pc+4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0). IF/ID <= {pc, pc+4, inst_in, valid=1}. fetch_cnt <= fetch_cnt+1, saturating at all-ones.
- HALT: pc frozen, IF/ID forced to bubble, all inputs ignored, halted=1. Only rst exits this state.
- Reset asserted mid-operation immediately forces reset values, including inside HALT.
- No X propagation: ifid_inst is 0, never inst_in, whenever ifid_valid=0.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INST = 32'h0000_0000
  - fetch-state enum {BOOT, RUN, HALT}
  - WORD_BYTES = 4
  - the default RESET_PC
- One natural combinational sub-module, fetch_next_pc. It takes pc, stall, jump/branch inputs and returns next_pc, redirect, and misaligned. The FSM and IF/ID register stay in inst_fetch.
- The bench instantiates the existing instruction ROM on inst_addr/inst_in.

Test Plan:
1. Sequential fetch: release reset with RESET_PC=0, no stall/redirect, ROM loaded with the standard test program -> 1 BOOT cycle. Then ifid_inst follows 0x00421821, 0x00621822, 0x00851820 with ifid_pc 0x0, 0x4, 0x8, valid=1, fetch_cnt 1, 2, 3.
2. Stall: assert stall for 3 cycles while ifid_pc=0x8 -> inst_addr stays 0xC and ifid holds 0x00851820 for 3 cycles. Next capture is 0x00831824 at ifid_pc 0xC.
3. Jump: when ifid_inst=0x08000007, drive jump=1, jump_target=0x1C for one cycle -> next cycle ifid_valid=0, inst=0. The following cycle ifid_pc=0x1C, inst=0xAC832710.
4. Branch with simultaneous stall: at ifid_inst=0x1063FFF7 (pc 0x24), drive branch_taken=1, branch_target=0x04, stall=1 -> redirect wins: pc becomes 0x04, one bubble, then inst 0x00621822.
5. Jump+branch together: jump_target=0x18, branch_target=0x08 -> pc becomes 0x18.
6. Misaligned target and recovery: branch_target=0x1E -> halted=1, ifid_valid=0, pc frozen for 10 cycles, fetch_cnt frozen. Then pulse rst mid-HALT -> all outputs return to reset values and fetch restarts at 0x0. Separately, with CNT_W=2, 5 sequential fetches -> fetch_cnt saturates at 3.
